// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one booth_multiplier among NREQ requesters
// and returns each signed product, tagged with its owner, on one response channel.
//
// state | meaning
// IDLE  | searching from rr_ptr for a valid requester
// START | one-cycle start pulse with registered operands
// WAIT  | waiting for multiplier done (first cycle masked)
// RESP  | product and id presented until accepted
module booth_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_multiplicand,
    output logic [WIDTH-1:0]        mul_multiplier,
    input  logic [2*WIDTH-1:0]      mul_product,
    input  logic                    mul_done,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t               state;
    state_t               state_next;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant;
    logic                 grant_found;
    logic                 first_wait;
    logic                 capture;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [IDW-1:0]       id_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     a_arr [NREQ];
    logic [WIDTH-1:0]     b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[IDW'((int'(rr_ptr) + k) % NREQ)]) begin
                grant       = IDW'((int'(rr_ptr) + k) % NREQ);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    // A level done still high from the previous operation must not be taken
    // as completion, so the first WAIT cycle never captures.
    assign capture = (state == WAIT) && !first_wait && mul_done;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (capture) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            first_wait <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            id_q       <= '0;
            product_q  <= '0;
        end else begin
            state      <= state_next;
            first_wait <= (state == START);
            if (state == IDLE && grant_found) begin
                op_a   <= a_arr[grant];
                op_b   <= b_arr[grant];
                id_q   <= grant;
                rr_ptr <= IDW'((int'(grant) + 1) % NREQ);
            end
            if (capture) begin
                product_q <= mul_product;
            end
        end
    end

    assign mul_start        = (state == START);
    assign mul_multiplicand = op_a;
    assign mul_multiplier   = op_b;
    assign rsp_valid        = (state == RESP);
    assign rsp_id           = id_q;
    assign rsp_product      = product_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: a behavioural multiplier stub with stale level-done,
// directed scenarios and randomized rounds checked against an arbitration model.
module tb_booth_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_multiplicand;
    logic [WIDTH-1:0]      mul_multiplier;
    logic [2*WIDTH-1:0]    mul_product;
    logic                  mul_done;
    logic                  busy;

    logic [WIDTH-1:0]      a_bits [NREQ];
    logic [WIDTH-1:0]      b_bits [NREQ];
    int                    opa [NREQ];
    int                    opb [NREQ];

    int n_checks;
    int n_fail;
    int lat;
    int mptr;
    int start_cnt;
    int ready_bad;
    logic [NREQ-1:0] keep_mask;
    bit  rand_rdy;

    int               grant_q [$];
    int               rid_q [$];
    logic [7:0]       rprod_q [$];
    logic [WIDTH-1:0] sa_q [$];
    logic [WIDTH-1:0] sb_q [$];
    int               exp_q [$];

    logic [NREQ-1:0]  snap_ready;
    logic             snap_rv;
    logic [IDW-1:0]   snap_id;
    logic [7:0]       snap_prod;
    logic             snap_start;
    logic [WIDTH-1:0] snap_ma;
    logic [WIDTH-1:0] snap_mb;
    logic             snap_busy;
    logic             snap_done;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*WIDTH +: WIDTH] = a_bits[g];
        assign req_b[g*WIDTH +: WIDTH] = b_bits[g];
    end

    always #5 clk = ~clk;

    booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product),
        .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product), .mul_done(mul_done),
        .busy(busy)
    );

    // Multiplier stand-in: done stays at its old level for one cycle after start.
    logic [WIDTH-1:0] st_a, st_b;
    int               st_cnt;
    logic             st_pend;
    always @(posedge clk) begin
        if (rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            st_pend     <= 1'b0;
            st_cnt      <= 0;
            st_a        <= '0;
            st_b        <= '0;
        end else if (mul_start) begin
            st_a    <= mul_multiplicand;
            st_b    <= mul_multiplier;
            st_cnt  <= lat;
            st_pend <= 1'b1;
        end else if (st_pend) begin
            if (st_cnt == 0) begin
                mul_done    <= 1'b1;
                mul_product <= $signed({{WIDTH{st_a[WIDTH-1]}}, st_a}) *
                               $signed({{WIDTH{st_b[WIDTH-1]}}, st_b});
                st_pend     <= 1'b0;
            end else begin
                mul_done <= 1'b0;
                st_cnt   <= st_cnt - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] model_prod(input int a, input int b);
        int p;
        p = a * b;
        return p[7:0];
    endfunction

    // Grant order for a set of one-shot requests, advancing the model pointer.
    task automatic model_batch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] m;
        int g;
        bit found;
        m = mask;
        exp_q.delete();
        while (m != 0) begin
            found = 0;
            g = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && m[IDW'((mptr + k) % NREQ)]) begin
                    g = (mptr + k) % NREQ;
                    found = 1;
                end
            end
            exp_q.push_back(g);
            m[IDW'(g)] = 1'b0;
            mptr = (g + 1) % NREQ;
        end
    endtask

    task automatic model_persistent(input logic [NREQ-1:0] mask, input int n);
        int g;
        bit found;
        exp_q.delete();
        for (int j = 0; j < n; j++) begin
            found = 0;
            g = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && mask[IDW'((mptr + k) % NREQ)]) begin
                    g = (mptr + k) % NREQ;
                    found = 1;
                end
            end
            exp_q.push_back(g);
            mptr = (g + 1) % NREQ;
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        snap_ready = req_ready;
        snap_rv    = rsp_valid;
        snap_id    = rsp_id;
        snap_prod  = rsp_product;
        snap_start = mul_start;
        snap_ma    = mul_multiplicand;
        snap_mb    = mul_multiplier;
        snap_busy  = busy;
        snap_done  = mul_done;
        if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 0) ready_bad++;
        acc = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) if (acc[IDW'(i)]) grant_q.push_back(i);
        if (rsp_valid && rsp_ready) begin
            rid_q.push_back(int'(rsp_id));
            rprod_q.push_back(rsp_product);
        end
        if (mul_start) begin
            start_cnt++;
            sa_q.push_back(mul_multiplicand);
            sb_q.push_back(mul_multiplier);
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc & ~keep_mask);
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic set_req(input int i, input int a, input int b);
        opa[IDW'(i)]    = a;
        opb[IDW'(i)]    = b;
        a_bits[IDW'(i)] = WIDTH'(a);
        b_bits[IDW'(i)] = WIDTH'(b);
        req_valid       = req_valid | (NREQ'(1) << i);
    endtask

    task automatic clear_logs();
        grant_q.delete(); rid_q.delete(); rprod_q.delete();
        sa_q.delete(); sb_q.delete();
        start_cnt = 0;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rid_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        ok = (rid_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({snap_ready, snap_rv, snap_id, snap_prod, snap_start, snap_ma, snap_mb, snap_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d prod=%h st=%b a=%h b=%h busy=%b, need all 0",
                     snap_ready, snap_rv, snap_id, snap_prod, snap_start, snap_ma, snap_mb, snap_busy);
        end
        rst = 1'b0;
        mptr = 0;
        tick();
        n_checks++;
        if ({snap_busy, snap_rv, snap_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b rv=%b start=%b, need 000", snap_busy, snap_rv, snap_start);
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        lat = 2;
        rsp_ready = 1'b1;
        set_req(0, -3, 5);
        model_batch(4'b0001);
        wait_rsp(1, 60, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got %0d responses, need 1", rid_q.size()); end
        n_checks++;
        if (start_cnt != 1) begin n_fail++; $display("FAIL single_start_pulses: got %0d, need 1", start_cnt); end
        if (ok) begin
            n_checks++;
            if ({sa_q[0], sb_q[0]} !== 8'hD5) begin
                n_fail++; $display("FAIL single_operands: got %h%h, need d5", sa_q[0], sb_q[0]);
            end
            n_checks++;
            if (rid_q[0] != exp_q[0]) begin n_fail++; $display("FAIL single_id: got %0d, need %0d", rid_q[0], exp_q[0]); end
            n_checks++;
            if (rprod_q[0] !== model_prod(-3, 5) || rprod_q[0] !== 8'hF1) begin
                n_fail++; $display("FAIL single_product: got %h, need f1", rprod_q[0]);
            end
        end
        tick();
        n_checks++;
        if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b, need 0", snap_busy); end
    endtask

    task automatic test_all_four();
        bit ok;
        logic [7:0] want [4];
        want[0] = 8'd8; want[1] = 8'd21; want[2] = 8'h40; want[3] = 8'hF9;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mptr = 0;
        clear_logs();
        lat = 1;
        set_req(0, -4, -2);
        set_req(1, 7, 3);
        set_req(2, -8, -8);
        set_req(3, -1, 7);
        model_batch(4'hF);
        wait_rsp(4, 200, ok);
        n_checks++;
        if (ok !== 1'b1 || grant_q.size() != 4) begin
            n_fail++; $display("FAIL all4_count: got %0d rsp %0d grants, need 4", rid_q.size(), grant_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < rid_q.size() && k < grant_q.size()) begin
                n_checks++;
                if (grant_q[k] != exp_q[k] || grant_q[k] != k || rid_q[k] != exp_q[k]) begin
                    n_fail++; $display("FAIL all4_order[%0d]: grant %0d id %0d, need %0d", k, grant_q[k], rid_q[k], k);
                end
                n_checks++;
                if (rprod_q[k] !== model_prod(opa[IDW'(exp_q[k])], opb[IDW'(exp_q[k])]) || rprod_q[k] !== want[k]) begin
                    n_fail++; $display("FAIL all4_product[%0d]: got %h, need %h", k, rprod_q[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_continuous();
        bit ok;
        int want [4];
        want[0] = 3; want[1] = 1; want[2] = 3; want[3] = 1;
        clear_logs();
        set_req(1, 2, 3);
        model_batch(4'b0010);
        wait_rsp(1, 60, ok);
        clear_logs();
        lat = 2;
        set_req(1, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
        set_req(3, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
        keep_mask = 4'b1010;
        model_persistent(4'b1010, 4);
        wait_rsp(4, 300, ok);
        keep_mask = '0;
        req_valid = '0;
        n_checks++;
        if (ok !== 1'b1 || grant_q.size() != 4) begin
            n_fail++; $display("FAIL rr_count: got %0d rsp %0d grants, need 4", rid_q.size(), grant_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < rid_q.size() && k < grant_q.size()) begin
                n_checks++;
                if (grant_q[k] != exp_q[k] || grant_q[k] != want[k] || rid_q[k] != want[k]) begin
                    n_fail++; $display("FAIL rr_order[%0d]: grant %0d id %0d, need %0d", k, grant_q[k], rid_q[k], want[k]);
                end
                n_checks++;
                if (rprod_q[k] !== model_prod(opa[IDW'(want[k])], opb[IDW'(want[k])])) begin
                    n_fail++; $display("FAIL rr_product[%0d]: got %h", k, rprod_q[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int c;
        clear_logs();
        rsp_ready = 1'b0;
        lat = 2;
        set_req(1, 7, 3);
        model_batch(4'b0010);
        c = 0;
        snap_rv = 1'b0;
        while (!snap_rv && c < 60) begin tick(); c++; end
        n_checks++;
        if (snap_rv !== 1'b1) begin n_fail++; $display("FAIL bp_reach_resp: rsp_valid %b, need 1", snap_rv); end
        set_req(0, int'($urandom_range(0, 15)) - 8, 5);
        set_req(2, -6, int'($urandom_range(0, 15)) - 8);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if ({snap_rv, snap_id, snap_prod, snap_ready} !== {1'b1, 2'd1, model_prod(7, 3), 4'b0000}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: rv=%b id=%0d prod=%h rdy=%b, need 1 1 15 0000",
                                   k, snap_rv, snap_id, snap_prod, snap_ready);
            end
        end
        rsp_ready = 1'b1;
        wait_rsp(1, 20, ok);
        n_checks++;
        if (ok !== 1'b1 || rid_q[0] != 1 || rprod_q[0] !== 8'd21 || grant_q.size() != 1) begin
            n_fail++; $display("FAIL bp_release: %0d rsp, grants %0d, need id 1 product 15h", rid_q.size(), grant_q.size());
        end
        model_batch(4'b0101);
        wait_rsp(3, 200, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_drain: got %0d responses, need 3", rid_q.size()); end
        for (int k = 0; k < 2; k++) begin
            if (k + 1 < rid_q.size()) begin
                n_checks++;
                if (rid_q[k+1] != exp_q[k] ||
                    rprod_q[k+1] !== model_prod(opa[IDW'(exp_q[k])], opb[IDW'(exp_q[k])])) begin
                    n_fail++; $display("FAIL bp_drain[%0d]: id %0d prod %h, need id %0d", k, rid_q[k+1], rprod_q[k+1], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_stale_done();
        bit ok;
        int c;
        clear_logs();
        rsp_ready = 1'b1;
        lat = 2;
        set_req(0, 7, 3);
        model_batch(4'b0001);
        wait_rsp(1, 60, ok);
        clear_logs();
        lat = 3;
        set_req(3, -2, 5);
        model_batch(4'b1000);
        c = 0;
        while (start_cnt == 0 && c < 20) begin tick(); c++; end
        tick();
        n_checks++;
        if (snap_done !== 1'b1) begin n_fail++; $display("FAIL stale_done_present: mul_done %b, need 1", snap_done); end
        tick();
        n_checks++;
        if (snap_rv !== 1'b0) begin n_fail++; $display("FAIL stale_done_masked: rsp_valid %b, need 0", snap_rv); end
        wait_rsp(1, 60, ok);
        n_checks++;
        if (ok !== 1'b1 || rid_q[0] != 3 || rprod_q[0] !== model_prod(-2, 5) || rprod_q[0] !== 8'hF6) begin
            n_fail++; $display("FAIL stale_done_product: %0d rsp, need id 3 product f6", rid_q.size());
            if (ok) $display("  got id %0d product %h", rid_q[0], rprod_q[0]);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int c;
        clear_logs();
        rsp_ready = 1'b1;
        lat = 4;
        set_req(2, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
        c = 0;
        while (start_cnt == 0 && c < 20) begin tick(); c++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mptr = 0;
        tick();
        n_checks++;
        if ({snap_ready, snap_rv, snap_id, snap_prod, snap_start, snap_ma, snap_mb, snap_busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_wait_outputs: rdy=%b rv=%b id=%0d prod=%h st=%b a=%h b=%h busy=%b, need all 0",
                     snap_ready, snap_rv, snap_id, snap_prod, snap_start, snap_ma, snap_mb, snap_busy);
        end
        for (int k = 0; k < 30; k++) tick();
        n_checks++;
        if (rid_q.size() != 0 || start_cnt != 1 || grant_q.size() != 1) begin
            n_fail++; $display("FAIL rst_wait_no_rsp: %0d responses %0d starts, need 0 and 1", rid_q.size(), start_cnt);
        end
        clear_logs();
        set_req(1, 3, -3);
        set_req(3, 5, 1);
        model_batch(4'b1010);
        wait_rsp(2, 100, ok);
        n_checks++;
        if (ok !== 1'b1 || rid_q[0] != exp_q[0] || rid_q[0] != 1 || rid_q[1] != 3) begin
            n_fail++; $display("FAIL rst_wait_ptr: %0d responses, need ids 1 then 3", rid_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [NREQ-1:0] mask;
        int n;
        rand_rdy = 1'b1;
        ready_bad = 0;
        for (int r = 0; r < 25; r++) begin
            clear_logs();
            lat  = int'($urandom_range(1, 4));
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (mask[IDW'(i)])
                    set_req(i, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
            end
            n = $countones(mask);
            model_batch(mask);
            wait_rsp(n, 400, ok);
            n_checks++;
            if (ok !== 1'b1 || grant_q.size() != n) begin
                n_fail++; $display("FAIL rand[%0d]_count: %0d rsp %0d grants, need %0d", r, rid_q.size(), grant_q.size(), n);
            end
            for (int k = 0; k < n; k++) begin
                if (k < rid_q.size() && k < grant_q.size()) begin
                    n_checks++;
                    if (grant_q[k] != exp_q[k] || rid_q[k] != exp_q[k] ||
                        rprod_q[k] !== model_prod(opa[IDW'(exp_q[k])], opb[IDW'(exp_q[k])])) begin
                        n_fail++; $display("FAIL rand[%0d]_rsp[%0d]: grant %0d id %0d prod %h, need id %0d prod %h",
                                           r, k, grant_q[k], rid_q[k], rprod_q[k], exp_q[k],
                                           model_prod(opa[IDW'(exp_q[k])], opb[IDW'(exp_q[k])]));
                    end
                end
            end
        end
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        n_checks++;
        if (ready_bad != 0) begin n_fail++; $display("FAIL ready_onehot: %0d bad cycles, need 0", ready_bad); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        keep_mask = '0;
        rand_rdy  = 1'b0;
        lat       = 2;
        mptr      = 0;
        ready_bad = 0;
        start_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            a_bits[IDW'(i)] = '0;
            b_bits[IDW'(i)] = '0;
            opa[IDW'(i)]    = 0;
            opb[IDW'(i)]    = 0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_continuous();
        test_backpressure();
        test_stale_done();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
